// File: rtl/move_input_ctrl_pkg.sv
// Game-wide button/direction codes plus the priority helpers used by the move
// input controller. The game-logic FSM imports the same direction codes.
package move_input_ctrl_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // Fixed priority up > down > left > right; only meaningful when p != 0.
  function automatic dir_t prio_dir(input logic [3:0] p);
    if (p[BTN_UP])        return DIR_UP;
    else if (p[BTN_DOWN]) return DIR_DOWN;
    else if (p[BTN_LEFT]) return DIR_LEFT;
    else                  return DIR_RIGHT;
  endfunction

  // True when more than one press bit is set, i.e. someone loses arbitration.
  function automatic logic multi_hot(input logic [3:0] p);
    return (p & (p - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Valid/ready move channel between the input controller and the game logic.
interface move_input_ctrl_if;
  import move_input_ctrl_pkg::*;

  logic move_valid;
  logic move_ready;
  dir_t move_dir;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);

endinterface

// File: rtl/move_input_ctrl_debounce_cell.sv
// One button lane: synchroniser, stability counter, debounced level and a
// single-cycle pulse one clock after the level rises.
module btn_debounce_cell #(
  parameter int STABLE_COUNT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic btn_raw,
  output logic btn_level,
  output logic press
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_btn;
  logic [3:0]             cnt;
  logic                   level_d;

  assign sync_btn = sync_q[SYNC_STAGES-1];

  // Shift the raw button through the metastability chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Flip the level only after STABLE_COUNT consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      btn_level <= 1'b0;
    end else if (sample_en) begin
      if (sync_btn != btn_level) begin
        if (cnt == CNT_LAST) begin
          btn_level <= sync_btn;
          cnt       <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

  // Registered rising-edge detect; releases produce nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= btn_level;
      press   <= btn_level & ~level_d;
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Move input controller: samples the buttons on each divided-clock rising
// edge, debounces them and hands one move per press to the game logic.
//
//   state | meaning
//   IDLE  | no move pending, waiting for a press
//   HOLD  | move_valid high, move_dir frozen until move_ready is seen
module move_input_ctrl
  import move_input_ctrl_pkg::*;
#(
  parameter int STABLE_COUNT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_clk,
  input  logic [3:0]         btn_raw,
  move_input_ctrl_if.master  mv,
  output logic [3:0]         btn_state,
  output logic               move_drop
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic       drop_q, drop_d;
  logic       tick_d;
  logic       sample_en;
  logic [3:0] press;

  assign sample_en = tick_clk & ~tick_d;

  // Delay the divided clock by one clk to find its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b0;
    else        tick_d <= tick_clk;
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce_cell #(
      .STABLE_COUNT (STABLE_COUNT),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_state[i]),
      .press     (press[i])
    );
  end

  // Handshake state, direction and drop pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      drop_q  <= drop_d;
    end
  end

  // Capture the winning press in IDLE; anything arriving in HOLD is dropped.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press != 4'd0) begin
          dir_d   = prio_dir(press);
          drop_d  = multi_hot(press);
          state_d = HOLD;
        end
      end
      HOLD: begin
        drop_d = (press != 4'd0);
        if (mv.move_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mv.move_valid = (state_q == HOLD);
  assign mv.move_dir   = dir_q;
  assign move_drop     = drop_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: directed scenarios plus random button/ready
// traffic, all compared every cycle against a behavioural model.
module tb_move_input_ctrl;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_clk = 1'b0;
  logic [3:0] btn_raw = 4'd0;
  logic [3:0] btn_state;
  logic       move_drop;

  move_input_ctrl_if mv_if ();

  move_input_ctrl #(.STABLE_COUNT(STABLE), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_clk  (tick_clk),
    .btn_raw   (btn_raw),
    .mv        (mv_if),
    .btn_state (btn_state),
    .move_drop (move_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // tick_clk toggles every 5 clk, so one sample every 10 clk.
  initial begin
    forever begin
      repeat (5) @(negedge clk);
      tick_clk = ~tick_clk;
    end
  end

  // Behavioural model: sync delay line, per-button run length of
  // disagreeing samples, press one clk after the level rises, and a single
  // pending-move slot.
  logic [3:0] m_pipe [SYNC];
  int         m_run [4];
  logic       m_tick_prev;
  logic [3:0] m_level, m_rose, m_rose_q, m_press, m_sync, m_lvl_new;
  logic       m_valid, m_drop, m_smp;
  logic [1:0] m_dir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = 4'd0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_tick_prev = 1'b0;
      m_level = 4'd0; m_rose_q = 4'd0; m_press = 4'd0;
      m_valid = 1'b0; m_drop = 1'b0; m_dir = 2'd0;
    end else begin
      m_smp = tick_clk && !m_tick_prev;
      m_sync = m_pipe[SYNC-1];
      m_lvl_new = m_level;
      m_rose = 4'd0;
      if (m_smp) begin
        for (int k = 0; k < 4; k++) begin
          if (m_sync[k] != m_level[k]) begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == STABLE) begin
              m_lvl_new[k] = m_sync[k];
              m_rose[k] = m_sync[k];
              m_run[k] = 0;
            end
          end else begin
            m_run[k] = 0;
          end
        end
      end
      if (!m_valid) begin
        m_drop = ($countones(m_press) > 1);
        if (m_press != 4'd0) begin
          m_valid = 1'b1;
          for (int k = 3; k >= 0; k--) if (m_press[k]) m_dir = 2'(k);
        end
      end else begin
        m_drop = (m_press != 4'd0);
        if (mv_if.move_ready) m_valid = 1'b0;
      end
      m_press = m_rose_q;
      m_rose_q = m_rose;
      m_level = m_lvl_new;
      for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = btn_raw;
      m_tick_prev = tick_clk;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", 32'(mv_if.move_valid), 32'(m_valid));
      chk("dir",   32'(mv_if.move_dir),   32'(m_dir));
      chk("btn_state", 32'(btn_state),    32'(m_level));
      chk("drop",  32'(move_drop),        32'(m_drop));
    end
  end

  int         hs_cnt = 0;
  int         drop_cnt = 0;
  logic [1:0] last_dir = 2'd0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (mv_if.move_valid && mv_if.move_ready) begin
        hs_cnt++;
        last_dir = mv_if.move_dir;
      end
      if (move_drop) drop_cnt++;
    end
  end

  task automatic wait_samples(input int n);
    repeat (n * 10) @(negedge clk);
  endtask

  task automatic ready_pulse();
    mv_if.move_ready = 1'b1;
    @(negedge clk);
    mv_if.move_ready = 1'b0;
  endtask

  int  hs0, dr0;
  bit  seen;

  initial begin
    mv_if.move_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_valid", 32'(mv_if.move_valid), 32'd0);
    chk("rst_dir",   32'(mv_if.move_dir),   32'd0);
    chk("rst_state", 32'(btn_state),        32'd0);
    chk("rst_drop",  32'(move_drop),        32'd0);
    rst_n = 1'b1;

    // Single press, held until ready.
    btn_raw = 4'b0001;
    wait_samples(6);
    chk("single_valid", 32'(mv_if.move_valid), 32'd1);
    chk("single_dir",   32'(mv_if.move_dir),   32'd0);
    ready_pulse();
    chk("single_after_ready", 32'(mv_if.move_valid), 32'd0);
    btn_raw = 4'b0000;
    wait_samples(6);

    // Bounce on right, then held; ready always high.
    hs0 = hs_cnt;
    mv_if.move_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      btn_raw = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      wait_samples(1);
    end
    btn_raw = 4'b1000;
    wait_samples(8);
    chk("bounce_moves", 32'(hs_cnt - hs0), 32'd1);
    chk("bounce_dir",   32'(last_dir),     32'd3);
    mv_if.move_ready = 1'b0;
    btn_raw = 4'b0000;
    wait_samples(6);

    // Simultaneous down+right.
    dr0 = drop_cnt;
    btn_raw = 4'b1010;
    wait_samples(6);
    chk("simul_valid", 32'(mv_if.move_valid), 32'd1);
    chk("simul_dir",   32'(mv_if.move_dir),   32'd1);
    chk("simul_drops", 32'(drop_cnt - dr0),   32'd1);
    ready_pulse();
    btn_raw = 4'b0000;
    wait_samples(6);

    // Backpressure: left pending, up pressed meanwhile.
    hs0 = hs_cnt;
    dr0 = drop_cnt;
    btn_raw = 4'b0100;
    wait_samples(6);
    btn_raw = 4'b0101;
    wait_samples(6);
    chk("bp_drops", 32'(drop_cnt - dr0),   32'd1);
    chk("bp_dir",   32'(mv_if.move_dir),   32'd2);
    ready_pulse();
    wait_samples(6);
    chk("bp_no_second", 32'(mv_if.move_valid), 32'd0);
    chk("bp_moves",     32'(hs_cnt - hs0),     32'd1);
    btn_raw = 4'b0000;
    wait_samples(6);

    // Held for 50 samples, then release and press again.
    hs0 = hs_cnt;
    mv_if.move_ready = 1'b1;
    btn_raw = 4'b0010;
    wait_samples(50);
    chk("held_moves", 32'(hs_cnt - hs0), 32'd1);
    btn_raw = 4'b0000;
    wait_samples(6);
    btn_raw = 4'b0010;
    wait_samples(6);
    chk("repeat_moves", 32'(hs_cnt - hs0), 32'd2);
    btn_raw = 4'b0000;
    wait_samples(6);

    // Random buttons and ready, model-checked every cycle.
    for (int it = 0; it < 40; it++) begin
      btn_raw = 4'($urandom_range(0, 15));
      repeat ($urandom_range(5, 60)) begin
        mv_if.move_ready = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    mv_if.move_ready = 1'b0;

    // Async reset mid-HOLD with the button still held.
    btn_raw = 4'b0000;
    wait_samples(6);
    ready_pulse();
    btn_raw = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = mv_if.move_valid;
    end
    chk("arst_reach_hold", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid_drop", 32'(mv_if.move_valid), 32'd0);
    chk("arst_state_clear", 32'(btn_state), 32'd0);
    @(negedge clk);
    chk("arst_no_drop", 32'(move_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_samples(6);
    chk("arst_new_valid", 32'(mv_if.move_valid), 32'd1);
    chk("arst_new_dir",   32'(mv_if.move_dir),   32'd1);
    ready_pulse();
    repeat (5) @(negedge clk);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
